// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache arbiter slice.
// Contents:
//   STR_UOP / LDR_UOP / NOP_UOP : dcache micro-op encodings
//   ADDR_W / DATA_W             : dcache word address and data widths
//   arb_state_t                 : arbiter FSM state encoding
//   sat_inc16                   : saturating 16-bit increment for statistics counters
package dcache_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [3:0] STR_UOP = 4'b1001;
    localparam logic [3:0] LDR_UOP = 4'b1010;
    localparam logic [3:0] NOP_UOP = 4'b0000;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } arb_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/dcache_arbiter_rr.sv
// rr_arbiter2: two-way round-robin arbiter.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req[1:0]     : request vector
//   advance      : when high, the current winner is recorded as last grant
//   grant[1:0]   : one-hot grant (combinational from req and last grant)
// After reset the last grant points at requester 1, so requester 0 wins
// the first conflict.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_r;

    // Pick the only requester, or on a conflict the one not granted last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the most recent winner to rotate priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_r <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_grant_r <= grant[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/dcache_arbiter.sv
// dcache_arbiter: shares the single-port dcache between the load/store unit
// (requester 0) and the debug/loader port (requester 1).
// Ports:
//   clock, reset                    : rising-edge clock, synchronous active-high reset
//   reqN_valid/uop/addr/wdata       : request from requester N
//   reqN_ready                      : request accepted this cycle
//   reqN_rvalid / reqN_rdata        : load response; rdata holds the last returned value
//   mem_addr / mem_data_in / mem_uop: drive the dcache
//   mem_data_out                    : dcache read data
// Optional build macro DCACHE_ARB_STATS_EN adds grant0_count, grant1_count and
// conflict_count (saturating 16-bit counters).
// One load may be outstanding; its response appears in the single LOAD_WAIT
// cycle that follows acceptance, during which no new request is granted.
module dcache_arbiter
    import dcache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [3:0]        req0_uop,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic [3:0]        req1_uop,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [3:0]        mem_uop,
    input  logic [DATA_W-1:0] mem_data_out
`ifdef DCACHE_ARB_STATS_EN
    ,
    output logic [15:0]       grant0_count,
    output logic [15:0]       grant1_count,
    output logic [15:0]       conflict_count
`endif
);

    arb_state_t        state_r;
    logic              owner_r;       // requester that owns the outstanding load
    logic [ADDR_W-1:0] addr_hold_r;   // last address driven; also the load address
    logic [DATA_W-1:0] wdata_hold_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;

    logic [1:0]        grant_s;
    logic              advance_s;
    logic [3:0]        win_uop_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    assign advance_s = (state_r == IDLE) && !reset;

    rr_arbiter2 u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     ({req1_valid, req0_valid}),
        .advance (advance_s),
        .grant   (grant_s)
    );

    // Select the winning requester's fields.
    always_comb begin
        if (grant_s[1]) begin
            win_uop_s   = req1_uop;
            win_addr_s  = req1_addr;
            win_wdata_s = req1_wdata;
        end else begin
            win_uop_s   = req0_uop;
            win_addr_s  = req0_addr;
            win_wdata_s = req0_wdata;
        end
    end

    // Handshake, response and dcache drive; reset forces everything quiet so a
    // load in flight when reset arrives never reports rvalid.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        req0_rvalid = 1'b0;
        req1_rvalid = 1'b0;
        req0_rdata  = rdata0_r;
        req1_rdata  = rdata1_r;
        mem_uop     = NOP_UOP;
        mem_addr    = addr_hold_r;
        mem_data_in = wdata_hold_r;
        if (reset) begin
            req0_rdata  = {DATA_W{1'b0}};
            req1_rdata  = {DATA_W{1'b0}};
            mem_addr    = {ADDR_W{1'b0}};
            mem_data_in = {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s != 2'b00) begin
                        req0_ready  = grant_s[0];
                        req1_ready  = grant_s[1];
                        mem_addr    = win_addr_s;
                        mem_data_in = win_wdata_s;
                        // Non-memory uops are accepted but cause no access.
                        if ((win_uop_s == STR_UOP) || (win_uop_s == LDR_UOP)) begin
                            mem_uop = win_uop_s;
                        end else begin
                            mem_uop = NOP_UOP;
                        end
                    end else begin
                        mem_uop = NOP_UOP;
                    end
                end
                LOAD_WAIT: begin
                    mem_uop = LDR_UOP;
                    if (owner_r) begin
                        req1_rvalid = 1'b1;
                        req1_rdata  = mem_data_out;
                    end else begin
                        req0_rvalid = 1'b1;
                        req0_rdata  = mem_data_out;
                    end
                end
                default: mem_uop = NOP_UOP;
            endcase
        end
    end

    // FSM: latch the winner's address/data, track the load owner, capture responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            addr_hold_r  <= {ADDR_W{1'b0}};
            wdata_hold_r <= {DATA_W{1'b0}};
            rdata0_r     <= {DATA_W{1'b0}};
            rdata1_r     <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s != 2'b00) begin
                        addr_hold_r  <= win_addr_s;
                        wdata_hold_r <= win_wdata_s;
                        if (win_uop_s == LDR_UOP) begin
                            owner_r <= grant_s[1];
                            state_r <= LOAD_WAIT;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD_WAIT: begin
                    if (owner_r) begin
                        rdata1_r <= mem_data_out;
                    end else begin
                        rdata0_r <= mem_data_out;
                    end
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_ARB_STATS_EN
    logic [15:0] grant0_cnt_r;
    logic [15:0] grant1_cnt_r;
    logic [15:0] conflict_cnt_r;

    // Saturating statistics: accepted requests per requester and IDLE conflicts.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant0_cnt_r   <= 16'd0;
            grant1_cnt_r   <= 16'd0;
            conflict_cnt_r <= 16'd0;
        end else if (state_r == IDLE) begin
            if (grant_s[0]) grant0_cnt_r <= sat_inc16(grant0_cnt_r);
            if (grant_s[1]) grant1_cnt_r <= sat_inc16(grant1_cnt_r);
            if (req0_valid && req1_valid) conflict_cnt_r <= sat_inc16(conflict_cnt_r);
        end else begin
            grant0_cnt_r   <= grant0_cnt_r;
            grant1_cnt_r   <= grant1_cnt_r;
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign grant0_count   = grant0_cnt_r;
    assign grant1_count   = grant1_cnt_r;
    assign conflict_count = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_dcache_arbiter.sv
// Self-checking bench for dcache_arbiter: a table of directed cycles with
// hand-computed outputs, followed by hand-written sequences for the load
// latency bound and (when DCACHE_ARB_STATS_EN is defined) the counters.
// The bench contains a behavioural single-port dcache: stores write on the
// clock edge, reads are combinational from mem_addr.
module tb_dcache_arbiter;
    import dcache_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]  req0_uop = 4'd0, req1_uop = 4'd0;
    logic [4:0]  req0_addr = 5'd0, req1_addr = 5'd0;
    logic [31:0] req0_wdata = 32'd0, req1_wdata = 32'd0;
    logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [31:0] req0_rdata, req1_rdata;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data_in, mem_data_out;
    logic [3:0]  mem_uop;
`ifdef DCACHE_ARB_STATS_EN
    logic [15:0] grant0_count, grant1_count, conflict_count;
`endif

    logic [31:0] mem [32];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_uop == 4'b1001) mem[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = mem[mem_addr];

    dcache_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_uop(req0_uop), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_uop(req1_uop), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_uop(mem_uop), .mem_data_out(mem_data_out)
`ifdef DCACHE_ARB_STATS_EN
        , .grant0_count(grant0_count), .grant1_count(grant1_count), .conflict_count(conflict_count)
`endif
    );

    typedef struct packed {
        logic        rst;
        logic        v0;
        logic [3:0]  u0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [3:0]  u1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        rdy0;
        logic        rdy1;
        logic        rv0;
        logic        rv1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [3:0]  uop;
        logic [4:0]  addr;
        logic [31:0] din;
    } vec_t;

    localparam logic [3:0] S = 4'b1001;
    localparam logic [3:0] L = 4'b1010;
    localparam logic [3:0] N = 4'b0000;
    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v0, input logic [3:0] u0, input logic [4:0] a0,
                         input logic [31:0] d0, input logic v1, input logic [3:0] u1,
                         input logic [4:0] a1, input logic [31:0] d1);
        reset = rst;
        req0_valid = v0; req0_uop = u0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_uop = u1; req1_addr = a1; req1_wdata = d1;
    endtask

    initial begin
        //          rst   v0    u0  a0     d0            v1    u1  a1     d1              rdy0  rdy1  rv0   rv1   rd0           rd1           uop addr   din
        vecs[0]  = '{1'b1, 1'b0, N, 5'h00, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, N, 5'h00, 32'h00000000};
        vecs[1]  = '{1'b0, 1'b1, S, 5'h0A, 32'h12345678, 1'b0, N, 5'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, S, 5'h0A, 32'h12345678};
        vecs[2]  = '{1'b0, 1'b1, L, 5'h0A, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, L, 5'h0A, 32'h00000000};
        vecs[3]  = '{1'b0, 1'b0, N, 5'h00, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h00000000, L, 5'h0A, 32'h00000000};
        vecs[4]  = '{1'b0, 1'b0, N, 5'h00, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h00000000, N, 5'h0A, 32'h00000000};
        vecs[5]  = '{1'b1, 1'b0, N, 5'h00, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, N, 5'h00, 32'h00000000};
        vecs[6]  = '{1'b0, 1'b1, S, 5'h01, 32'h11111111, 1'b1, S, 5'h05, 32'hAABBCCDD, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, S, 5'h01, 32'h11111111};
        vecs[7]  = '{1'b0, 1'b1, S, 5'h02, 32'h22222222, 1'b1, S, 5'h05, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000, S, 5'h05, 32'hAABBCCDD};
        vecs[8]  = '{1'b0, 1'b1, S, 5'h02, 32'h22222222, 1'b1, S, 5'h06, 32'h66666666, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, S, 5'h02, 32'h22222222};
        vecs[9]  = '{1'b0, 1'b1, S, 5'h03, 32'h33333333, 1'b1, S, 5'h06, 32'h66666666, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000, S, 5'h06, 32'h66666666};
        vecs[10] = '{1'b0, 1'b1, S, 5'h03, 32'h33333333, 1'b0, N, 5'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, S, 5'h03, 32'h33333333};
        vecs[11] = '{1'b0, 1'b1, S, 5'h07, 32'h77777777, 1'b1, L, 5'h05, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000, L, 5'h05, 32'h00000000};
        vecs[12] = '{1'b0, 1'b1, S, 5'h07, 32'h77777777, 1'b0, N, 5'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'hAABBCCDD, L, 5'h05, 32'h00000000};
        vecs[13] = '{1'b0, 1'b1, S, 5'h07, 32'h77777777, 1'b0, N, 5'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'hAABBCCDD, S, 5'h07, 32'h77777777};
        vecs[14] = '{1'b0, 1'b1, 4'b0010, 5'h07, 32'hFFFFFFFF, 1'b0, N, 5'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'hAABBCCDD, N, 5'h07, 32'hFFFFFFFF};
        vecs[15] = '{1'b0, 1'b1, L, 5'h07, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'hAABBCCDD, L, 5'h07, 32'h00000000};
        vecs[16] = '{1'b0, 1'b0, N, 5'h00, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h77777777, 32'hAABBCCDD, L, 5'h07, 32'h00000000};
        vecs[17] = '{1'b0, 1'b0, N, 5'h00, 32'h00000000, 1'b1, L, 5'h01, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h77777777, 32'hAABBCCDD, L, 5'h01, 32'h00000000};
        vecs[18] = '{1'b1, 1'b0, N, 5'h00, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, N, 5'h00, 32'h00000000};
        vecs[19] = '{1'b0, 1'b0, N, 5'h00, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, N, 5'h00, 32'h00000000};
        vecs[20] = '{1'b0, 1'b0, N, 5'h00, 32'h00000000, 1'b1, L, 5'h01, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000, L, 5'h01, 32'h00000000};
        vecs[21] = '{1'b0, 1'b0, N, 5'h00, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h11111111, L, 5'h01, 32'h00000000};
        vecs[22] = '{1'b0, 1'b0, N, 5'h00, 32'h00000000, 1'b0, N, 5'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h11111111, N, 5'h01, 32'h00000000};

        repeat (2) @(posedge clock);

        // Table: drive on the falling edge, compare 1 time unit later.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            drive(vecs[i].rst, vecs[i].v0, vecs[i].u0, vecs[i].a0, vecs[i].d0,
                  vecs[i].v1, vecs[i].u1, vecs[i].a1, vecs[i].d1);
            #1;
            chk($sformatf("v%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].rdy0});
            chk($sformatf("v%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].rdy1});
            chk($sformatf("v%0d req0_rvalid", i), {31'd0, req0_rvalid}, {31'd0, vecs[i].rv0});
            chk($sformatf("v%0d req1_rvalid", i), {31'd0, req1_rvalid}, {31'd0, vecs[i].rv1});
            chk($sformatf("v%0d req0_rdata", i), req0_rdata, vecs[i].rd0);
            chk($sformatf("v%0d req1_rdata", i), req1_rdata, vecs[i].rd1);
            chk($sformatf("v%0d mem_uop", i), {28'd0, mem_uop}, {28'd0, vecs[i].uop});
            chk($sformatf("v%0d mem_addr", i), {27'd0, mem_addr}, {27'd0, vecs[i].addr});
            chk($sformatf("v%0d mem_data_in", i), mem_data_in, vecs[i].din);
        end

        // Reset, then 3 conflicting store cycles (winners 0,1,0) and 2 solo req0 stores.
        @(negedge clock);
        drive(1'b1, 1'b0, N, 5'h00, 32'h0, 1'b0, N, 5'h00, 32'h0);
        @(negedge clock);
        drive(1'b0, 1'b1, S, 5'h10, 32'hA0A0A0A0, 1'b1, S, 5'h11, 32'hB1B1B1B1);
        #1 chk("conf1 req0_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clock);
        drive(1'b0, 1'b1, S, 5'h12, 32'hA2A2A2A2, 1'b1, S, 5'h11, 32'hB1B1B1B1);
        #1 chk("conf2 req1_ready", {31'd0, req1_ready}, 32'd1);
        @(negedge clock);
        drive(1'b0, 1'b1, S, 5'h12, 32'hA2A2A2A2, 1'b1, S, 5'h13, 32'hB3B3B3B3);
        #1 chk("conf3 req0_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clock);
        drive(1'b0, 1'b1, S, 5'h14, 32'hA4A4A4A4, 1'b0, N, 5'h00, 32'h0);
        #1 chk("solo1 req0_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clock);
        drive(1'b0, 1'b1, S, 5'h15, 32'hA5A5A5A5, 1'b0, N, 5'h00, 32'h0);
        #1 chk("solo2 req0_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clock);
        drive(1'b0, 1'b0, N, 5'h00, 32'h0, 1'b0, N, 5'h00, 32'h0);
`ifdef DCACHE_ARB_STATS_EN
        #1;
        chk("conflict_count", {16'd0, conflict_count}, 32'd3);
        chk("grant0_count", {16'd0, grant0_count}, 32'd4);
        chk("grant1_count", {16'd0, grant1_count}, 32'd1);
`endif

        // Load latency: data must appear in the cycle right after acceptance.
        @(negedge clock);
        drive(1'b0, 1'b1, L, 5'h12, 32'h0, 1'b0, N, 5'h00, 32'h0);
        #1 chk("lat req0_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clock);
        drive(1'b0, 1'b0, N, 5'h00, 32'h0, 1'b0, N, 5'h00, 32'h0);
        #1;
        begin
            int wait_cycles;
            wait_cycles = 0;
            while (!req0_rvalid && wait_cycles < 4) begin
                @(negedge clock);
                #1;
                wait_cycles++;
            end
            chk("lat cycles", wait_cycles, 32'd0);
            chk("lat req0_rdata", req0_rdata, 32'hA2A2A2A2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_arbiter.md
Name: dcache_arbiter

Overview:
- Shares the single-port dcache between two requesters.
  - Requester 0: the execute-stage load/store unit.
  - Requester 1: the debug/loader port.
- Each requester uses a valid/ready request handshake and an rvalid response for loads.
- The block drives the dcache addr/data_in/uop inputs directly and returns dcache data_out to the load owner.
- Arbitration is round-robin. At most one load is outstanding at a time.

Parameters:
- STR_UOP, 4'b1001, dcache store micro-op encoding
- LDR_UOP, 4'b1010, dcache load micro-op encoding
- NOP_UOP, 4'b0000, micro-op driven when the dcache is idle
- ADDR_W, 5, dcache word address width
- DATA_W, 32, data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_uop / req1_uop  in  4  requested micro-op
- req0_addr / req1_addr  in  ADDR_W  word address
- req0_wdata / req1_wdata  in  DATA_W  store data
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_rvalid / req1_rvalid  out  1  load data valid this cycle
- req0_rdata / req1_rdata  out  DATA_W  load data
- mem_addr  out  ADDR_W  to dcache addr
- mem_data_in  out  DATA_W  to dcache data_in
- mem_uop  out  4  to dcache uop
- mem_data_out  in  DATA_W  from dcache data_out

Behaviour:
- The clock is `clock`. Reset is synchronous and active-high on `reset`, sampled on the rising edge of `clock`.
- FSM states: IDLE, LOAD_WAIT.
- Reset:
  - state goes to IDLE; last_grant goes to 1, so requester 0 wins the first conflict.
  - All ready and rvalid outputs are 0, rdata is 0, mem_uop = NOP_UOP, mem_addr = 0, mem_data_in = 0.
- IDLE:
  - Winner selection: the single valid requester. If both are valid, the requester other than last_grant.
  - The winner gets ready = 1 combinationally in the same cycle, and last_grant takes the winner on the clock edge.
  - mem_addr and mem_data_in are driven from the winner.
  - mem_uop is driven from the winner's uop if it equals STR_UOP or LDR_UOP; otherwise it is NOP_UOP (request accepted, no access).
  - STR: the dcache writes on this edge. State stays IDLE, so back-to-back stores are allowed at 1 per cycle.
  - LDR: addr and owner are latched; next state is LOAD_WAIT.
  - No valid requester: mem_uop = NOP_UOP, mem_addr and mem_data_in hold their last value.
- LOAD_WAIT (exactly 1 cycle):
  - mem_uop = LDR_UOP with the latched addr.
  - The owner's rvalid = 1 and its rdata = mem_data_out, both combinational this cycle.
  - Both ready outputs are 0, and the losing requester keeps its valid request pending.
  - Next state is IDLE.
- Load latency: request accepted in cycle N, data returned in cycle N+1. The next grant happens no earlier than N+2.
- The non-owner's rvalid is always 0. rdata of a requester not in rvalid holds its last returned value.
- Requester rules: valid must be held until ready. uop/addr/wdata are stable while valid and not ready (the bench checks this; no RTL check).
- Reset during LOAD_WAIT: the response is dropped (rvalid stays 0) and state returns to IDLE.
- Simultaneous store and load from different requesters: only the round-robin winner proceeds; the other is served on a later IDLE cycle.

Optional Feature:
- Macro DCACHE_ARB_STATS_EN. When defined, the block adds these outputs:
  - grant0_count [15:0] and grant1_count [15:0]: increment on each accepted request of that requester.
  - conflict_count [15:0]: increments on each IDLE cycle where both requesters are valid.
- All three counters saturate at 16'hFFFF and are cleared by reset.
- When the macro is undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package dcache_pkg holds:
  - the uop constants STR_UOP, LDR_UOP, NOP_UOP;
  - ADDR_W and DATA_W;
  - the FSM state encoding (IDLE = 1'b0, LOAD_WAIT = 1'b1).
- Sub-module rr_arbiter2: 2-way round-robin with inputs req[1:0], an advance enable, and clock/reset; outputs one-hot grant[1:0].
- The FSM, muxing and statistics counters stay in dcache_arbiter.

Test Plan:
- Single store then load, requester 0:
  - STR addr 5'b01010 with wdata 32'h12345678 gives req0_ready in the same cycle and mem_uop = 1001.
  - A following LDR to the same addr gives req0_rvalid one cycle after acceptance with rdata = 32'h12345678.
- Conflict:
  - Both requesters valid with STR in the first cycle after reset gives req0 granted first and req1 granted in the next cycle.
  - Repeated conflicts alternate 0, 1, 0, 1.
- Load blocking:
  - req1 LDR addr 5'b00101 (previously stored 32'hAABBCCDD) is accepted while req0 is also valid.
  - In the next cycle req0_ready = 0 and req1_rvalid = 1 with rdata = 32'hAABBCCDD; req0 is accepted in the cycle after.
- Non-memory uop: req0 uop 4'b0010 gives ready = 1 with mem_uop = 0000, no rvalid, and dcache contents unchanged.
- Reset mid-load: assert reset in the LOAD_WAIT cycle; no rvalid is seen, outputs go to reset values, and the next request is served normally.
- With DCACHE_ARB_STATS_EN defined: 3 conflicting cycles plus 2 solo req0 grants give conflict_count = 3, grant0 = 2 + number of conflicts won by req0, and grant1 = conflicts won by req1.
